// File: rtl/event_order_checker.sv
// Registered monitor for the ev1 -> ev2 -> ev3 pulse order within a timeout window.
// Optional macro EVORD_STICKY_ERR_EN: errors park in ERR until err_clr.
module event_order_checker #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ev1,
    input  logic       ev2,
    input  logic       ev3,
`ifdef EVORD_STICKY_ERR_EN
    input  logic       err_clr,
`endif
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [3:0] seq_count,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT2 = 2'b01,
        S_WAIT3 = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_ORDER = 2'b01;
    localparam logic [1:0] C_SIMUL = 2'b10;
    localparam logic [1:0] C_TMO   = 2'b11;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef EVORD_STICKY_ERR_EN
    localparam state_t ERR_DST = S_ERR;
`else
    localparam state_t ERR_DST = S_IDLE;
`endif

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [3:0]       count_q, count_d;

    logic             hit_done;
    logic             hit_err;
    logic [1:0]       kind;
    logic             tmo;

    assign tmo = (timer_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= C_NONE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        hit_done = 1'b0;
        hit_err  = 1'b0;
        kind     = C_NONE;
        if (!en && state_q != S_ERR) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev1 && (ev2 || ev3)) begin
                        hit_err = 1'b1;
                        kind    = C_SIMUL;
                    end else if (ev1) begin
                        state_d = S_WAIT2;
                        timer_d = '0;
                    end
                end
                S_WAIT2: begin
                    if ((ev1 && (ev2 || ev3)) || (ev2 && ev3)) begin
                        hit_err = 1'b1;
                        kind    = C_SIMUL;
                    end else if (ev2) begin
                        state_d = S_WAIT3;
                        timer_d = '0;
                    end else if (ev3) begin
                        hit_err = 1'b1;
                        kind    = C_ORDER;
                    end else if (ev1) begin
                        timer_d = '0;
                    end else if (tmo) begin
                        hit_err = 1'b1;
                        kind    = C_TMO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT3: begin
                    // repeated ev1/ev2 are legal but do not count as progress
                    if (ev3 && (ev1 || ev2)) begin
                        hit_err = 1'b1;
                        kind    = C_SIMUL;
                    end else if (ev3) begin
                        hit_done = 1'b1;
                        state_d  = S_IDLE;
                        timer_d  = '0;
                    end else if (tmo) begin
                        hit_err = 1'b1;
                        kind    = C_TMO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_ERR: begin
`ifdef EVORD_STICKY_ERR_EN
                    if (err_clr) begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            endcase
            if (hit_err) begin
                state_d = ERR_DST;
                timer_d = '0;
            end
        end
    end

    always_comb begin
        done_d  = hit_done;
`ifdef EVORD_STICKY_ERR_EN
        err_d   = (state_d == S_ERR);
`else
        err_d   = hit_err;
`endif
        code_d  = hit_err ? kind : code_q;
        count_d = count_q + {3'b000, hit_done};
        busy_d  = (state_d == S_WAIT2) || (state_d == S_WAIT3);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign seq_count = count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_event_order_checker.sv
// Bench for event_order_checker: directed scenarios plus random traffic
// against a stage/idle-count reference model.
module tb_event_order_checker;

    localparam int T = 16;
`ifdef EVORD_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [1:0] ERR_ST = STICKY ? 2'b11 : 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ev1 = 1'b0, ev2 = 1'b0, ev3 = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic [3:0] seq_count;
    logic [1:0] state_o;

    int total = 0;
    int bad = 0;

    // model: stage 0 idle, 1 want ev2, 2 want ev3, 3 sticky error
    int         stage, idle, m_cnt;
    logic [1:0] m_code;
    logic       m_done, m_err;

    event_order_checker #(.TIMEOUT_CYCLES(T), .TMR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ev1(ev1), .ev2(ev2), .ev3(ev3),
`ifdef EVORD_STICKY_ERR_EN
        .err_clr(err_clr),
`endif
        .busy(busy), .done(done), .err(err),
        .err_code(err_code), .seq_count(seq_count),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {busy, done, err, err_code, seq_count, state_o};
    endfunction

    function automatic logic [10:0] expv();
        logic b;
        b = (stage == 1) || (stage == 2);
        return {b, m_done, m_err, m_code, 4'(m_cnt), 2'(stage)};
    endfunction

    task automatic model_reset();
        stage = 0; idle = 0; m_cnt = 0;
        m_code = 2'b00; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [2:0] v,
                              input logic clr);
        int n;
        logic [1:0] ek;
        n = int'(v[0]) + int'(v[1]) + int'(v[2]);
        ek = 2'b00;
        m_done = 1'b0;
        if (stage == 3) begin
            if (clr) stage = 0;
        end else if (!e) begin
            stage = 0; idle = 0;
        end else if (stage == 0) begin
            if (v[0] && n > 1) ek = 2'b10;
            else if (v[0]) begin stage = 1; idle = 0; end
        end else if (stage == 1) begin
            if (n > 1) ek = 2'b10;
            else if (v[1]) begin stage = 2; idle = 0; end
            else if (v[2]) ek = 2'b01;
            else if (v[0]) idle = 0;
            else begin
                idle++;
                if (idle == T) ek = 2'b11;
            end
        end else begin
            if (v[2] && n > 1) ek = 2'b10;
            else if (v[2]) begin m_done = 1'b1; stage = 0; idle = 0; end
            else begin
                idle++;
                if (idle == T) ek = 2'b11;
            end
        end
        if (ek != 2'b00) begin
            m_code = ek; idle = 0;
            stage = STICKY ? 3 : 0;
        end
        if (m_done) m_cnt = (m_cnt + 1) % 16;
        m_err = STICKY ? (stage == 3) : (ek != 2'b00);
    endtask

    task automatic tick(input logic e, input logic [2:0] v,
                        input logic clr);
        en = e; ev1 = v[0]; ev2 = v[1]; ev3 = v[2]; err_clr = clr;
        @(posedge clk);
        model_step(e, v, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; err_clr = 1'b0;
        ev1 = 1'b0; ev2 = 1'b0; ev3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== 11'd0) begin
            bad++;
            $display("FAIL reset got=%h want=0", obs());
        end
    endtask

    task automatic test_in_order();
        logic [2:0] s [8] = '{3'b001, 3'b000, 3'b000, 3'b010,
                              3'b000, 3'b000, 3'b100, 3'b000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, s[i], 1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL in_order i=%0d got=%h want=%h", i, obs(), expv());
            end
            total++;
            if (busy !== (i < 6) || err !== 1'b0 || done !== (i == 6)) begin
                bad++;
                $display("FAIL in_order_flags i=%0d busy=%b done=%b err=%b",
                         i, busy, done, err);
            end
        end
        total++;
        if (seq_count !== 4'd1) begin
            bad++;
            $display("FAIL in_order_count got=%0d want=1", seq_count);
        end
    endtask

    task automatic test_order_err();
        logic [2:0] s [3] = '{3'b001, 3'b000, 3'b100};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, s[i], 1'b0);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL order i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        total++;
        if (err !== 1'b1 || err_code !== 2'b01 || state_o !== ERR_ST
            || seq_count !== 4'd0) begin
            bad++;
            $display("FAIL order_err err=%b code=%b st=%b cnt=%0d want 1/01/%b/0",
                     err, err_code, state_o, seq_count, ERR_ST);
        end
    endtask

    task automatic test_simul();
        logic [2:0] s [3] = '{3'b001, 3'b000, 3'b110};
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, s[i], 1'b0);
        total++;
        if (err !== 1'b1 || err_code !== 2'b10 || obs() !== expv()) begin
            bad++;
            $display("FAIL simul_w2 got=%h want=%h code=%b", obs(), expv(), err_code);
        end
        do_reset();
        tick(1'b1, 3'b011, 1'b0);
        total++;
        if (err !== 1'b1 || err_code !== 2'b10 || state_o !== ERR_ST) begin
            bad++;
            $display("FAIL simul_idle err=%b code=%b st=%b want 1/10/%b",
                     err, err_code, state_o, ERR_ST);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1'b1, 3'b001, 1'b0);
        for (int i = 1; i <= T; i++) begin
            tick(1'b1, 3'b000, 1'b0);
            total++;
            if (err !== (i == T) || obs() !== expv()) begin
                bad++;
                $display("FAIL timeout i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        total++;
        if (err_code !== 2'b11) begin
            bad++;
            $display("FAIL timeout_code got=%b want=11", err_code);
        end
        do_reset();
        tick(1'b1, 3'b001, 1'b0);
        for (int i = 1; i < T; i++) tick(1'b1, 3'b000, 1'b0);
        tick(1'b1, 3'b010, 1'b0);
        total++;
        if (err !== 1'b0 || state_o !== 2'b10 || obs() !== expv()) begin
            bad++;
            $display("FAIL timeout_win got=%h want=%h", obs(), expv());
        end
        tick(1'b1, 3'b100, 1'b0);
        total++;
        if (done !== 1'b1 || seq_count !== 4'd1) begin
            bad++;
            $display("FAIL timeout_done done=%b cnt=%0d want 1/1", done, seq_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] s [3] = '{3'b001, 3'b010, 3'b100};
        do_reset();
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < 3; i++) begin
                tick(1'b1, s[i], 1'b0);
                total++;
                if (obs() !== expv()) begin
                    bad++;
                    $display("FAIL b2b k=%0d i=%0d got=%h want=%h",
                             k, i, obs(), expv());
                end
            end
        end
        total++;
        if (seq_count !== 4'd1) begin
            bad++;
            $display("FAIL wrap got=%0d want=1", seq_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 3'b001, 1'b0);
        tick(1'b1, 3'b010, 1'b0);
        ev2 = 1'b0; ev3 = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs() !== 11'd0) begin
            bad++;
            $display("FAIL async_rst got=%h want=0", obs());
        end
        @(negedge clk);
        rst = 1'b0; ev3 = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (obs() !== 11'd0) begin
            bad++;
            $display("FAIL async_rst_after got=%h want=0", obs());
        end
    endtask

    task automatic test_enable();
        logic [2:0] s [5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
        logic       e [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(e[i], s[i], 1'b0);
            total++;
            if (obs() !== expv() || done !== 1'b0) begin
                bad++;
                $display("FAIL enable i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

`ifdef EVORD_STICKY_ERR_EN
    task automatic test_sticky();
        logic [2:0] s [3] = '{3'b001, 3'b010, 3'b100};
        do_reset();
        tick(1'b1, 3'b001, 1'b0);
        tick(1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(i[0], 3'b001, 1'b0);
            total++;
            if (err !== 1'b1 || err_code !== 2'b01 || state_o !== 2'b11) begin
                bad++;
                $display("FAIL sticky_hold i=%0d err=%b code=%b st=%b",
                         i, err, err_code, state_o);
            end
        end
        tick(1'b1, 3'b000, 1'b1);
        total++;
        if (err !== 1'b0 || err_code !== 2'b01 || state_o !== 2'b00) begin
            bad++;
            $display("FAIL sticky_clr err=%b code=%b st=%b want 0/01/00",
                     err, err_code, state_o);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, s[i], 1'b0);
        total++;
        if (done !== 1'b1 || obs() !== expv()) begin
            bad++;
            $display("FAIL sticky_seq got=%h want=%h", obs(), expv());
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0] v;
        logic       e, c;
        int         p;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            p = ((i / 150) % 2 == 1) ? 3 : 30;
            e = ($urandom_range(0, 31) != 0);
            v[0] = ($urandom_range(0, p - 1) == 0);
            v[1] = ($urandom_range(0, p - 1) == 0);
            v[2] = ($urandom_range(0, p - 1) == 0);
            c = ($urandom_range(0, 7) == 0);
            tick(e, v, c);
            total++;
            if (obs() !== expv()) begin
                bad++;
                $display("FAIL random i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_order_err();
        test_simul();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_enable();
`ifdef EVORD_STICKY_ERR_EN
        test_sticky();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
